io_responder: RTL and testbench

Peripheral-side responder for the processor's input-halt handshake. When the control unit raises its halt request for an input instruction, this block waits for an operator confirmation on a debounced pushbutton. It then captures a switch bank and returns the value sign-extended to 32 bits. It acknowledges with `peripheral_signal`, which releases the halted core. It sits between board I/O (button, switches) and the control unit / register-bank write path.

---
 rtl/io_responder.sv | 161 ++++++++++++++++
 tb/tb_io_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// Input-halt responder: debounced button confirms capture of a sign-extended switch bank.
// Optional ARMED-state timeout is built when IO_RESPONDER_TIMEOUT_EN is defined.
module io_responder #(
    parameter int SW_WIDTH        = 10,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                halt_request,
    input  logic                button_raw,
    input  logic [SW_WIDTH-1:0] switches,
    output logic                peripheral_signal,
    output logic [31:0]         input_data,
    output logic                timed_out,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    state_t              cur;
    state_t              nxt;
    logic                btn_m;
    logic                btn_s;
    logic [SW_WIDTH-1:0] sw_m;
    logic [SW_WIDTH-1:0] sw_s;
    logic                btn_db;
    logic                btn_db_q;
    logic [DB_W-1:0]     db_cnt;
    logic                press;
    logic                capture;
    logic                take_timeout;
    logic                expire;
    logic [31:0]         sw_ext;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= button_raw;
            btn_s <= btn_m;
            sw_m  <= switches;
            sw_s  <= sw_m;
        end
    end

    // The counter only advances while the synchronized level disagrees with the
    // debounced level, so it clears on any bounce and can never wrap.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press  = btn_db & ~btn_db_q;
    assign sw_ext = 32'(signed'(sw_s));

`ifdef IO_RESPONDER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (cur == ARMED && nxt == ARMED) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign expire = (to_cnt == TO_LAST);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            timed_out <= 1'b0;
        end else if (capture) begin
            timed_out <= 1'b0;
        end else if (take_timeout) begin
            timed_out <= 1'b1;
        end
    end
`else
    assign expire    = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_comb begin
        nxt          = cur;
        capture      = 1'b0;
        take_timeout = 1'b0;
        case (cur)
            IDLE: begin
                if (halt_request) nxt = ARMED;
            end
            ARMED: begin
                // Withdrawal of the request outranks a simultaneous press or timeout.
                if (!halt_request) begin
                    nxt = IDLE;
                end else if (press) begin
                    nxt     = ACK;
                    capture = 1'b1;
                end else if (expire) begin
                    nxt          = ACK;
                    take_timeout = 1'b1;
                end
            end
            ACK: begin
                if (!halt_request) nxt = RELEASE;
            end
            RELEASE: begin
                if (!btn_db) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cur               <= IDLE;
            peripheral_signal <= 1'b0;
            input_data        <= '0;
        end else begin
            cur               <= nxt;
            peripheral_signal <= (nxt == ACK);
            if (capture) begin
                input_data <= sw_ext;
            end else if (take_timeout) begin
                input_data <= '0;
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_io_responder.sv
// Directed and randomized checks of io_responder against an arithmetic reference model.
// Timeout expectations follow IO_RESPONDER_TIMEOUT_EN when it is defined for the build.
module tb_io_responder;

    localparam int SW  = 10;
    localparam int DB  = 4;
    localparam int TMO = 20;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic          clock;
    logic          rst;
    logic          halt_request;
    logic          button_raw;
    logic [SW-1:0] switches;
    logic          peripheral_signal;
    logic [31:0]   input_data;
    logic          timed_out;
    logic [1:0]    state;

    int          errors;
    int          checks;
    logic [31:0] exp_data;

    io_responder #(
        .SW_WIDTH        (SW),
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clock             (clock),
        .rst               (rst),
        .halt_request      (halt_request),
        .button_raw        (button_raw),
        .switches          (switches),
        .peripheral_signal (peripheral_signal),
        .input_data        (input_data),
        .timed_out         (timed_out),
        .state             (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Value of an SW-bit two's-complement number, re-encoded as 32 bits.
    function automatic logic [31:0] sext(input int unsigned v);
        int signed s;
        s = (v >= (1 << (SW - 1))) ? int'(v) - (1 << SW) : int'(v);
        return 32'(s);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        int unsigned sw_val;
        int          nb;
        logic        seen;

        errors       = 0;
        checks       = 0;
        exp_data     = '0;
        rst          = 1'b0;
        halt_request = 1'b0;
        button_raw   = 1'b0;
        switches     = '0;

        tick(2);
        check("reset_state", 32'(state), 32'(S_IDLE));
        check("reset_ack", 32'(peripheral_signal), 32'd0);
        check("reset_data", input_data, 32'd0);
        check("reset_tmo", 32'(timed_out), 32'd0);
        rst = 1'b1;
        tick(2);

        // Normal handshake, all-ones switches
        switches     = 10'h3FF;
        halt_request = 1'b1;
        tick(2);
        check("norm_armed", 32'(state), 32'(S_ARMED));
        button_raw = 1'b1;
        tick(DB + 2);
        check("norm_ack_early", 32'(peripheral_signal), 32'd0);
        tick(1);
        check("norm_ack_rise", 32'(peripheral_signal), 32'd1);
        exp_data = sext(32'h3FF);
        check("norm_data", input_data, exp_data);
        check("norm_tmo", 32'(timed_out), 32'd0);
        tick(3);
        check("norm_ack_hold", 32'(peripheral_signal), 32'd1);
        halt_request = 1'b0;
        tick(1);
        check("norm_ack_fall", 32'(peripheral_signal), 32'd0);
        check("norm_release", 32'(state), 32'(S_RELEASE));
        tick(4);
        check("norm_release_held", 32'(state), 32'(S_RELEASE));
        button_raw = 1'b0;
        tick(8);
        check("norm_idle", 32'(state), 32'(S_IDLE));

        // Bouncy press: five toggles two cycles apart, last one held
        switches     = 10'h155;
        halt_request = 1'b1;
        tick(2);
        repeat (2) begin
            button_raw = 1'b1;
            tick(2);
            button_raw = 1'b0;
            tick(2);
        end
        check("bounce_no_ack", 32'(peripheral_signal), 32'd0);
        button_raw = 1'b1;
        tick(DB + 2);
        check("bounce_ack_early", 32'(peripheral_signal), 32'd0);
        tick(1);
        check("bounce_ack", 32'(peripheral_signal), 32'd1);
        exp_data = sext(32'h155);
        check("bounce_data", input_data, exp_data);
        halt_request = 1'b0;
        button_raw   = 1'b0;
        tick(9);
        check("bounce_idle", 32'(state), 32'(S_IDLE));

        // Button already held when the request arrives
        switches   = 10'h2A0;
        button_raw = 1'b1;
        tick(10);
        halt_request = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick(1);
            seen = seen | peripheral_signal;
        end
        check("held_no_ack", 32'(seen), 32'd0);
        check("held_armed", 32'(state), 32'(S_ARMED));
        button_raw = 1'b0;
        tick(7);
        button_raw = 1'b1;
        tick(DB + 2);
        check("held_ack_early", 32'(peripheral_signal), 32'd0);
        tick(1);
        check("held_ack", 32'(peripheral_signal), 32'd1);
        exp_data = sext(32'h2A0);
        check("held_data", input_data, exp_data);
        halt_request = 1'b0;
        button_raw   = 1'b0;
        tick(9);
        check("held_idle", 32'(state), 32'(S_IDLE));

        // Abort while armed
        switches     = 10'h0F0;
        halt_request = 1'b1;
        tick(3);
        check("abort_armed", 32'(state), 32'(S_ARMED));
        halt_request = 1'b0;
        tick(1);
        check("abort_idle", 32'(state), 32'(S_IDLE));
        seen = 1'b0;
        repeat (6) begin
            tick(1);
            seen = seen | peripheral_signal;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        check("abort_data", input_data, exp_data);

        // Randomized handshakes against the model
        for (int t = 0; t < 8; t++) begin
            sw_val       = $urandom_range(0, (1 << SW) - 1);
            nb           = int'($urandom_range(0, 2));
            switches     = SW'(sw_val);
            halt_request = 1'b1;
            tick(3);
            check("rnd_armed", 32'(state), 32'(S_ARMED));
            for (int b = 0; b < nb; b++) begin
                button_raw = 1'b1;
                tick(2);
                button_raw = 1'b0;
                tick(2);
            end
            button_raw = 1'b1;
            tick(DB + 2);
            check("rnd_ack_early", 32'(peripheral_signal), 32'd0);
            tick(1);
            check("rnd_ack", 32'(peripheral_signal), 32'd1);
            exp_data = sext(sw_val);
            check("rnd_data", input_data, exp_data);
            check("rnd_tmo", 32'(timed_out), 32'd0);
            halt_request = 1'b0;
            tick(1);
            check("rnd_ack_fall", 32'(peripheral_signal), 32'd0);
            button_raw = 1'b0;
            tick(8);
            check("rnd_idle", 32'(state), 32'(S_IDLE));
        end

        // Asynchronous reset in the middle of ACK
        switches     = 10'h3C3;
        halt_request = 1'b1;
        tick(3);
        button_raw = 1'b1;
        tick(DB + 3);
        check("rst_pre_ack", 32'(peripheral_signal), 32'd1);
        check("rst_pre_data", input_data, sext(32'h3C3));
        #2 rst = 1'b0;
        #1;
        check("rst_async_state", 32'(state), 32'(S_IDLE));
        check("rst_async_ack", 32'(peripheral_signal), 32'd0);
        check("rst_async_data", input_data, 32'd0);
        check("rst_async_tmo", 32'(timed_out), 32'd0);
        exp_data     = '0;
        halt_request = 1'b0;
        button_raw   = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(3);
        check("rst_after_idle", 32'(state), 32'(S_IDLE));

        // Request with no press
        switches     = 10'h1FF;
        halt_request = 1'b1;
`ifdef IO_RESPONDER_TIMEOUT_EN
        tick(TMO);
        check("tmo_still_armed", 32'(state), 32'(S_ARMED));
        tick(1);
        check("tmo_ack_state", 32'(state), 32'(S_ACK));
        check("tmo_ack", 32'(peripheral_signal), 32'd1);
        check("tmo_data", input_data, 32'd0);
        check("tmo_flag", 32'(timed_out), 32'd1);
        halt_request = 1'b0;
        tick(2);
        check("tmo_idle", 32'(state), 32'(S_IDLE));
`else
        seen = 1'b0;
        repeat (100) begin
            tick(1);
            seen = seen | peripheral_signal;
        end
        check("wait_no_ack", 32'(seen), 32'd0);
        check("wait_armed", 32'(state), 32'(S_ARMED));
        check("wait_tmo", 32'(timed_out), 32'd0);
        check("wait_data", input_data, exp_data);
        halt_request = 1'b0;
        tick(1);
        check("wait_idle", 32'(state), 32'(S_IDLE));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
